// File: rtl/rom_loader_pkg.sv
// Shared definitions for the HACK instruction-memory loader.
package rom_loader_pkg;

    // Address and word widths of the HACK machine, also used by the CPU and RAM.
    localparam int HACK_ADDR_W = 15;
    localparam int HACK_WORD_W = 16;

    // Loader FSM states, in the order a byte stream walks through them.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_CNT_HI  = 3'd1,
        ST_CNT_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4
    } rom_state_t;

endpackage : rom_loader_pkg

// File: rtl/rom_array.sv
// DEPTH x 16 instruction storage: one synchronous write port, one
// asynchronous read port. Out-of-range reads return zero and
// out-of-range writes are dropped. Contents are never reset.
module rom_array
    import rom_loader_pkg::*;
#(
    parameter int DEPTH = 32768
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [HACK_ADDR_W-1:0] waddr,
    input  logic [HACK_WORD_W-1:0] wdata,
    input  logic [HACK_ADDR_W-1:0] raddr,
    output logic [HACK_WORD_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [HACK_WORD_W-1:0] mem [DEPTH];

    logic waddr_ok;
    logic raddr_ok;

    // Range checks done on the full 15-bit addresses so small arrays never alias.
    always_comb begin
        waddr_ok = ({17'd0, waddr} < DEPTH);
        raddr_ok = ({17'd0, raddr} < DEPTH);
    end

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Asynchronous read port; addresses beyond the array read as zero.
    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem[raddr[AW-1:0]];
        end
    end

endmodule : rom_array

// File: rtl/rom_loader.sv
// Instruction-memory stage for the HACK core. Serves inst for pc from an
// internal ROM, and accepts a new program over a byte stream:
//   SYNC_BYTE, count[14:8], count[7:0], then count words as hi/lo byte pairs.
// The core is held in reset for the whole load so it restarts at pc=0.
// Handshake: the FSM consumes rx_data only on cycles where rx_valid=1; there
// is no back-pressure, every strobed byte is taken on that rising edge.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         DEPTH     = 32768,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic [HACK_ADDR_W-1:0] pc,
    output logic [HACK_WORD_W-1:0] inst,
    output logic                   cpu_reset,
    output logic                   loading,
    output logic                   load_done,
    output logic                   overflow,
    output rom_state_t             fsm_state
);

    rom_state_t             state_q, state_d;
    logic [HACK_ADDR_W-1:0] count_q, count_d;
    logic [HACK_ADDR_W-1:0] ptr_q, ptr_d;
    logic [HACK_ADDR_W-1:0] ptr_inc;
    logic [7:0]             hi_q, hi_d;
    logic                   loading_q, loading_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   ptr_in_range;
    logic                   we;
    logic [HACK_WORD_W-1:0] rdata;

    rom_array #(
        .DEPTH (DEPTH)
    ) u_rom (
        .clk   (clk),
        .we    (we),
        .waddr (ptr_q),
        .wdata ({hi_q, rx_data}),
        .raddr (pc),
        .rdata (rdata)
    );

    // State and datapath registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            count_q   <= '0;
            ptr_q     <= '0;
            hi_q      <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            hi_q      <= hi_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic: advances only on strobed bytes.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ptr_d        = ptr_q;
        hi_d         = hi_q;
        loading_d    = loading_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        we           = 1'b0;
        ptr_inc      = ptr_q + 15'd1;
        ptr_in_range = ({17'd0, ptr_q} < DEPTH);
        if (rx_valid) begin
            case (state_q)
                ST_RUN: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d   = ST_CNT_HI;
                        loading_d = 1'b1;
                        ovf_d     = 1'b0;
                    end
                end
                ST_CNT_HI: begin
                    // Bit 7 of the high count byte is ignored: count is 15 bits.
                    count_d[14:8] = rx_data[6:0];
                    state_d       = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    count_d[7:0] = rx_data;
                    ptr_d        = '0;
                    if ({count_q[14:8], rx_data} == 15'd0) begin
                        state_d   = ST_RUN;
                        loading_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hi_d    = rx_data;
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    // Words beyond the array are counted but dropped.
                    if (ptr_in_range) begin
                        we = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    ptr_d = ptr_inc;
                    if (ptr_inc == count_q) begin
                        state_d   = ST_RUN;
                        loading_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                default: begin
                    state_d   = ST_RUN;
                    loading_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs: the core sees a blank instruction and stays in reset while loading.
    always_comb begin
        inst      = loading_q ? '0 : rdata;
        cpu_reset = reset | loading_q;
        loading   = loading_q;
        load_done = done_q;
        overflow  = ovf_q;
        fsm_state = state_q;
    end

endmodule : rom_loader
